// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment debug display: display modes,
// digit count and the active-low hex glyph decoder.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam logic [1:0] MODE_PC      = 2'b00;
    localparam logic [1:0] MODE_REG     = 2'b01;
    localparam logic [1:0] MODE_MEM     = 2'b10;
    localparam logic [1:0] MODE_REGADDR = 2'b11;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_debug_disp_btn.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic btnRaw,
    output logic stepPulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          syncMeta;
    logic          syncOut;
    logic          level;
    logic          levelQ;
    logic [CW-1:0] stableCnt;

    // The counter runs only while the sample disagrees with the accepted
    // level, so any bounce back to the old level restarts the window.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            syncMeta  <= 1'b0;
            syncOut   <= 1'b0;
            level     <= 1'b0;
            levelQ    <= 1'b0;
            stableCnt <= '0;
        end else begin
            syncMeta <= btnRaw;
            syncOut  <= syncMeta;
            levelQ   <= level;
            if (syncOut == level) begin
                stableCnt <= '0;
            end else if (stableCnt == LAST_COUNT) begin
                level     <= syncOut;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

    assign stepPulse = level & ~levelQ;

endmodule

// File: rtl/seg7_debug_disp.sv
// Debug display for the MIPS board: button-stepped debug read addresses and
// an 8-digit multiplexed hex view of PC, register or memory contents.
module seg7_debug_disp
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  Mode,
    input  logic        BtnNext,
    input  logic        BtnPrev,
    input  logic [31:0] PC,
    input  logic [31:0] PCNext,
    input  logic [31:0] DispRegData,
    input  logic [31:0] DispMemData,
    output logic [4:0]  DispReadReg,
    output logic [5:0]  DispReadMem,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [2:0]    LAST_DIGIT   = 3'(DIGITS - 1);

    logic          stepNext;
    logic          stepPrev;
    logic [RW-1:0] refreshCnt;
    logic [2:0]    digitIdx;
    logic          firstTc;
    logic          termCount;
    logic [31:0]   snapshot;
    logic          snapIsPc;
    logic [31:0]   modeWord;
    logic [3:0]    curNibble;
    logic          unusedPcHigh;

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uBtnNext (
        .CLK       (CLK),
        .Reset     (Reset),
        .btnRaw    (BtnNext),
        .stepPulse (stepNext)
    );

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uBtnPrev (
        .CLK       (CLK),
        .Reset     (Reset),
        .btnRaw    (BtnPrev),
        .stepPulse (stepPrev)
    );

    assign unusedPcHigh = ^{PC[31:16], PCNext[31:16]};

    always_comb begin
        modeWord = 32'h0;
        case (Mode)
            MODE_PC:      modeWord = {PC[15:0], PCNext[15:0]};
            MODE_REG:     modeWord = DispRegData;
            MODE_MEM:     modeWord = DispMemData;
            MODE_REGADDR: modeWord = {3'b000, DispReadReg, DispRegData[23:0]};
            default:      modeWord = 32'h0;
        endcase
    end

    assign termCount = (refreshCnt == REFRESH_LAST);
    assign curNibble = snapshot[{digitIdx, 2'b00} +: 4];

    // Scan timing and frame snapshot; the snapshot only moves at a frame
    // boundary so a mode or address change never splits one frame.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            refreshCnt <= '0;
            digitIdx   <= 3'd0;
            firstTc    <= 1'b1;
            snapshot   <= 32'h0;
            snapIsPc   <= 1'b0;
        end else if (termCount) begin
            refreshCnt <= '0;
            digitIdx   <= digitIdx + 3'd1;
            firstTc    <= 1'b0;
            if ((digitIdx == LAST_DIGIT) || firstTc) begin
                snapshot <= modeWord;
                snapIsPc <= (Mode == MODE_PC);
            end
        end else begin
            refreshCnt <= refreshCnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            DispReadReg <= 5'd0;
            DispReadMem <= 6'd0;
        end else if (stepNext ^ stepPrev) begin
            case (Mode)
                MODE_REG, MODE_REGADDR:
                    DispReadReg <= stepNext ? DispReadReg + 5'd1 : DispReadReg - 5'd1;
                MODE_MEM:
                    DispReadMem <= stepNext ? DispReadMem + 6'd1 : DispReadMem - 6'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            AN  <= 8'hFE;
            SEG <= 7'h40;
            DP  <= 1'b1;
        end else begin
            AN  <= ~(8'b0000_0001 << digitIdx);
            SEG <= hex_to_seg(curNibble);
            DP  <= ~((digitIdx == 3'd4) && snapIsPc);
        end
    end

endmodule

// File: tb/tb_seg7_debug_disp.sv
// Self-checking bench for seg7_debug_disp with fast refresh and debounce.
module tb_seg7_debug_disp;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Mode = 2'b00;
    logic        BtnNext = 1'b0;
    logic        BtnPrev = 1'b0;
    logic [31:0] PC = 32'h0;
    logic [31:0] PCNext = 32'h0;
    logic [31:0] DispRegData = 32'h0;
    logic [31:0] DispMemData = 32'h0;
    logic [4:0]  DispReadReg;
    logic [5:0]  DispReadMem;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int asserts = 0;
    int failures = 0;
    int modelReg = 0;
    int modelMem = 0;

    logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_debug_disp #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Mode        (Mode),
        .BtnNext     (BtnNext),
        .BtnPrev     (BtnPrev),
        .PC          (PC),
        .PCNext      (PCNext),
        .DispRegData (DispRegData),
        .DispMemData (DispMemData),
        .DispReadReg (DispReadReg),
        .DispReadMem (DispReadMem),
        .AN          (AN),
        .SEG         (SEG),
        .DP          (DP)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] expWord(input logic [1:0] m);
        logic [31:0] w;
        case (m)
            2'd0:    w = ((PC % 32'h10000) << 16) + (PCNext % 32'h10000);
            2'd1:    w = DispRegData;
            2'd2:    w = DispMemData;
            default: w = (32'(modelReg) << 24) + (DispRegData % 32'h01000000);
        endcase
        return w;
    endfunction

    // Holds the buttons long enough to debounce both edges and updates the model.
    task automatic pressBtn(input logic n, input logic p);
        @(negedge CLK);
        BtnNext = n;
        BtnPrev = p;
        repeat (8) @(negedge CLK);
        BtnNext = 1'b0;
        BtnPrev = 1'b0;
        repeat (8) @(negedge CLK);
        if (n != p) begin
            if (Mode == 2'd1 || Mode == 2'd3)
                modelReg = n ? (modelReg + 1) % 32 : (modelReg + 31) % 32;
            else if (Mode == 2'd2)
                modelMem = n ? (modelMem + 1) % 64 : (modelMem + 63) % 64;
        end
    endtask

    task automatic test_reset;
        int seen;
        @(negedge CLK);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        asserts++;
        if (AN !== 8'hFE) begin failures++; $display("FAIL reset_an: got %h want fe", AN); end
        asserts++;
        if (SEG !== 7'h40) begin failures++; $display("FAIL reset_seg: got %h want 40", SEG); end
        asserts++;
        if (DP !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", DP); end
        asserts++;
        if (DispReadReg !== 5'd0 || DispReadMem !== 6'd0) begin
            failures++;
            $display("FAIL reset_addr: got reg %0d mem %0d want 0 0", DispReadReg, DispReadMem);
        end
        Reset = 1'b0;
        modelReg = 0;
        modelMem = 0;
        seen = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (AN === 8'hFD) begin
                seen = c;
                break;
            end
        end
        asserts++;
        if (seen != 5) begin failures++; $display("FAIL reset_first_step: AN=fd after %0d cycles want 5", seen); end
    endtask

    task automatic test_display;
        logic [31:0] w;
        logic        isPc;
        logic [7:0]  oh;
        logic [3:0]  nib;
        int          idx;
        int          perDigit [8];
        for (int t = 0; t < 7; t++) begin
            @(negedge CLK);
            if (t == 0) begin
                Mode = 2'd0;
                PC = 32'h00400010;
                PCNext = 32'h00400014;
            end else begin
                Mode = 2'($urandom_range(0, 3));
                PC = $urandom;
                PCNext = $urandom;
                DispRegData = $urandom;
                DispMemData = $urandom;
            end
            w = expWord(Mode);
            isPc = (Mode == 2'd0);
            for (int i = 0; i < 8; i++) perDigit[i] = 0;
            repeat (80) @(negedge CLK);
            for (int c = 0; c < 32; c++) begin
                @(negedge CLK);
                idx = -1;
                for (int i = 0; i < 8; i++) begin
                    oh = 8'b1 << i;
                    if (AN === ~oh) idx = i;
                end
                asserts++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL disp_an_onehot: got %h want one-hot-zero", AN);
                end else begin
                    perDigit[idx]++;
                    nib = 4'((w >> (4 * idx)) & 32'hF);
                    asserts++;
                    if (SEG !== glyphTab[nib]) begin
                        failures++;
                        $display("FAIL disp_seg: mode %0d digit %0d got %h want %h", Mode, idx, SEG, glyphTab[nib]);
                    end
                    asserts++;
                    if (DP !== ((isPc && idx == 4) ? 1'b0 : 1'b1)) begin
                        failures++;
                        $display("FAIL disp_dp: mode %0d digit %0d got %b", Mode, idx, DP);
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                asserts++;
                if (perDigit[i] != 4) begin
                    failures++;
                    $display("FAIL disp_dwell: digit %0d lit %0d cycles want 4", i, perDigit[i]);
                end
            end
        end
    endtask

    task automatic test_reg_step;
        @(negedge CLK);
        Mode = 2'd1;
        BtnNext = 1'b1;
        repeat (20) @(negedge CLK);
        BtnNext = 1'b0;
        repeat (10) @(negedge CLK);
        modelReg = (modelReg + 1) % 32;
        asserts++;
        if (DispReadReg !== 5'(modelReg)) begin
            failures++;
            $display("FAIL reg_hold_once: got %0d want %0d", DispReadReg, modelReg);
        end
        for (int i = 0; i < 31; i++) pressBtn(1'b1, 1'b0);
        asserts++;
        if (DispReadReg !== 5'(modelReg)) begin
            failures++;
            $display("FAIL reg_wrap_up: got %0d want %0d", DispReadReg, modelReg);
        end
        pressBtn(1'b0, 1'b1);
        asserts++;
        if (DispReadReg !== 5'(modelReg)) begin
            failures++;
            $display("FAIL reg_wrap_down: got %0d want %0d", DispReadReg, modelReg);
        end
        asserts++;
        if (DispReadMem !== 6'(modelMem)) begin
            failures++;
            $display("FAIL reg_mem_untouched: got %0d want %0d", DispReadMem, modelMem);
        end
    endtask

    task automatic test_mem_step;
        @(negedge CLK);
        Mode = 2'd2;
        BtnNext = 1'b1;
        repeat (2) @(negedge CLK);
        BtnNext = 1'b0;
        repeat (10) @(negedge CLK);
        asserts++;
        if (DispReadMem !== 6'(modelMem)) begin
            failures++;
            $display("FAIL mem_glitch: got %0d want %0d", DispReadMem, modelMem);
        end
        pressBtn(1'b1, 1'b1);
        asserts++;
        if (DispReadMem !== 6'(modelMem)) begin
            failures++;
            $display("FAIL mem_both: got %0d want %0d", DispReadMem, modelMem);
        end
        pressBtn(1'b0, 1'b1);
        asserts++;
        if (DispReadMem !== 6'(modelMem)) begin
            failures++;
            $display("FAIL mem_wrap_down: got %0d want %0d", DispReadMem, modelMem);
        end
        pressBtn(1'b1, 1'b0);
        asserts++;
        if (DispReadMem !== 6'(modelMem)) begin
            failures++;
            $display("FAIL mem_wrap_up: got %0d want %0d", DispReadMem, modelMem);
        end
        Mode = 2'd0;
        pressBtn(1'b1, 1'b0);
        asserts++;
        if (DispReadMem !== 6'(modelMem) || DispReadReg !== 5'(modelReg)) begin
            failures++;
            $display("FAIL mode_pc_ignore: got reg %0d mem %0d want %0d %0d",
                     DispReadReg, DispReadMem, modelReg, modelMem);
        end
    endtask

    task automatic test_random_steps;
        for (int i = 0; i < 12; i++) begin
            Mode = 2'($urandom_range(0, 3));
            pressBtn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            asserts++;
            if (DispReadReg !== 5'(modelReg) || DispReadMem !== 6'(modelMem)) begin
                failures++;
                $display("FAIL rand_step: got reg %0d mem %0d want %0d %0d",
                         DispReadReg, DispReadMem, modelReg, modelMem);
            end
        end
    endtask

    task automatic test_mode_switch;
        int c;
        @(negedge CLK);
        Mode = 2'd1;
        DispRegData = 32'h11111111;
        DispMemData = 32'h22222222;
        repeat (80) @(negedge CLK);
        c = 0;
        while (AN !== 8'hFE && c < 40) begin @(negedge CLK); c++; end
        c = 0;
        while (AN !== 8'hF7 && c < 40) begin @(negedge CLK); c++; end
        asserts++;
        if (c >= 40) begin failures++; $display("FAIL switch_find_digit3: AN stuck at %h", AN); end
        Mode = 2'd2;
        c = 0;
        @(negedge CLK);
        while (AN !== 8'hFE && c < 40) begin
            asserts++;
            if (SEG !== 7'h79) begin
                failures++;
                $display("FAIL switch_old_frame: AN %h got %h want 79", AN, SEG);
            end
            @(negedge CLK);
            c++;
        end
        asserts++;
        if (c != 19) begin failures++; $display("FAIL switch_remaining: got %0d cycles want 19", c); end
        for (int i = 0; i < 32; i++) begin
            asserts++;
            if (SEG !== 7'h24) begin
                failures++;
                $display("FAIL switch_new_frame: AN %h got %h want 24", AN, SEG);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid;
        Mode = 2'd1;
        pressBtn(1'b1, 1'b0);
        repeat ($urandom_range(1, 20)) @(negedge CLK);
        BtnNext = 1'b1;
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        BtnNext = 1'b0;
        @(negedge CLK);
        asserts++;
        if (AN !== 8'hFE || SEG !== 7'h40 || DP !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs: got AN %h SEG %h DP %b want fe 40 1", AN, SEG, DP);
        end
        asserts++;
        if (DispReadReg !== 5'd0 || DispReadMem !== 6'd0) begin
            failures++;
            $display("FAIL midreset_addr: got reg %0d mem %0d want 0 0", DispReadReg, DispReadMem);
        end
        Reset = 1'b0;
        modelReg = 0;
        modelMem = 0;
        repeat (20) @(negedge CLK);
        asserts++;
        if (DispReadReg !== 5'd0) begin
            failures++;
            $display("FAIL midreset_no_pulse: got reg %0d want 0", DispReadReg);
        end
    endtask

    initial begin
        test_reset();
        test_display();
        test_reg_step();
        test_mem_step();
        test_random_steps();
        test_display();
        test_mode_switch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
